// File: rtl/perm_vector_loader.sv
// Serial-to-parallel vector loader feeding the 257-point permutation stage.
// Ports: clk, rst (sync, active-high); in_data/in_valid/in_ready/in_sel/in_last
//   serial input; out_list/out_sel/out_valid/out_ready vector output;
//   fill_count, sel_err, frame_err status.
// Optional: define PERM_VECTOR_LOADER_LAST_CHECK_EN to enable in_last framing.
module perm_vector_loader #(
  parameter int SIZE  = 257,
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(SIZE + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [WIDTH-1:0]             in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [2:0]                   in_sel,
  input  logic                         in_last,
  output logic [SIZE-1:0][WIDTH-1:0]   out_list,
  output logic [2:0]                   out_sel,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CNT_W-1:0]             fill_count,
  output logic                         sel_err,
  output logic                         frame_err
);

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(SIZE - 1);

  state_t state;
  logic   acc;
  logic   fire;
  logic   first_beat;
  logic   last_beat;

  // in_ready depends only on registered state, never on out_ready.
  assign in_ready   = (state == FILL) & ~rst;
  assign acc        = in_valid & in_ready;
  assign fire       = out_valid & out_ready;
  assign first_beat = (fill_count == '0);
  assign last_beat  = (fill_count == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FILL;
      fill_count <= '0;
      out_valid  <= 1'b0;
      out_sel    <= 3'd0;
      out_list   <= '0;
      sel_err    <= 1'b0;
    end else begin
      unique case (state)
        FILL: begin
          if (acc) begin
            out_list[fill_count] <= in_data;
            fill_count           <= fill_count + 1'b1;
            if (first_beat) begin
              // Select 3 is reserved: substitute 0 and flag it.
              if (in_sel == 3'd3) begin
                out_sel <= 3'd0;
                sel_err <= 1'b1;
              end else begin
                out_sel <= in_sel;
              end
            end
`ifdef PERM_VECTOR_LOADER_LAST_CHECK_EN
            if (last_beat || in_last) begin
              state     <= FULL;
              out_valid <= 1'b1;
            end
`else
            if (last_beat) begin
              state     <= FULL;
              out_valid <= 1'b1;
            end
`endif
          end
        end
        FULL: begin
          if (fire) begin
            state      <= FILL;
            fill_count <= '0;
            out_valid  <= 1'b0;
            out_list   <= '0;
          end
        end
        default: begin
          state <= FILL;
        end
      endcase
    end
  end

`ifdef PERM_VECTOR_LOADER_LAST_CHECK_EN
  // Early in_last closes a short vector; missing in_last on the final word
  // still closes normally. Both are framing errors.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_err <= 1'b0;
    end else if (acc) begin
      if (in_last && !last_beat) begin
        frame_err <= 1'b1;
      end
      if (!in_last && last_beat) begin
        frame_err <= 1'b1;
      end
    end
  end
`else
  // Framing check disabled: resets to 0 and can never set.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_err <= 1'b0;
    end else begin
      frame_err <= frame_err & in_last;
    end
  end
`endif

endmodule

// File: tb/tb_perm_vector_loader.sv
// Directed self-checking bench for perm_vector_loader.
// Covers reset, streaming, gaps, drain, reserved select, mid-fill reset, in_last.
module tb_perm_vector_loader;

  localparam int SIZE  = 257;
  localparam int WIDTH = 32;
  localparam int CNT_W = 9;

  logic                       clk;
  logic                       rst;
  logic [WIDTH-1:0]           in_data;
  logic                       in_valid;
  logic                       in_ready;
  logic [2:0]                 in_sel;
  logic                       in_last;
  logic [SIZE-1:0][WIDTH-1:0] out_list;
  logic [2:0]                 out_sel;
  logic                       out_valid;
  logic                       out_ready;
  logic [CNT_W-1:0]           fill_count;
  logic                       sel_err;
  logic                       frame_err;

  logic [SIZE-1:0][WIDTH-1:0] exp_v;

  int checks;
  int errors;
  int pre_bad;

  perm_vector_loader #(.SIZE(SIZE), .WIDTH(WIDTH)) dut (
    .clk(clk),
    .rst(rst),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_sel(in_sel),
    .in_last(in_last),
    .out_list(out_list),
    .out_sel(out_sel),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .fill_count(fill_count),
    .sel_err(sel_err),
    .frame_err(frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic build_exp(input int base, input int n);
    exp_v = '0;
    for (int i = 0; i < n; i++) begin
      exp_v[i] = WIDTH'(base + i);
    end
  endtask

  function automatic int ndiff();
    int d;
    d = 0;
    for (int i = 0; i < SIZE; i++) begin
      if (out_list[i] !== exp_v[i]) d++;
    end
    return d;
  endfunction

  // Feed up to n words; stops early if in_ready drops.
  task automatic load(input int base, input logic [2:0] s0,
                      input logic [2:0] sn, input int n,
                      input int lastmark, input bit gaps,
                      output int cyc, output int acc);
    cyc = 0;
    acc = 0;
    pre_bad = 0;
    for (int i = 0; i < n; i++) begin
      if (!in_ready) break;
      if (out_valid) pre_bad++;
      in_valid = 1'b1;
      in_data  = WIDTH'(base + i);
      in_sel   = (i == 0) ? s0 : sn;
      in_last  = (i == lastmark);
      step();
      cyc++;
      acc++;
      if (gaps && i != n - 1) begin
        in_valid = 1'b0;
        step();
        cyc++;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    int d;
    rst = 1'b1;
    step();
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_ready: got %b want 0", in_ready);
    end
    step();
    rst = 1'b0;
    #1;
    d = ndiff();
    checks++;
    if (fill_count !== '0 || out_valid !== 1'b0 || out_sel !== 3'd0 ||
        d != 0) begin
      errors++;
      $display("FAIL reset_state: fc=%0d ov=%b sel=%0d diffs=%0d want 0,0,0,0",
               fill_count, out_valid, out_sel, d);
    end
    checks++;
    if (sel_err !== 1'b0 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: sel_err=%b frame_err=%b want 0 0",
               sel_err, frame_err);
    end
  endtask

  task automatic test_stream();
    int cyc, acc, d;
    build_exp(1, SIZE);
    load(1, 3'd2, 3'd2, SIZE, SIZE - 1, 1'b0, cyc, acc);
    checks++;
    if (acc != SIZE || cyc != SIZE || pre_bad != 0) begin
      errors++;
      $display("FAIL stream_ready: acc=%0d cyc=%0d early_valid=%0d want %0d %0d 0",
               acc, cyc, pre_bad, SIZE, SIZE);
    end
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL stream_valid: ov=%b ir=%b want 1 0", out_valid, in_ready);
    end
    d = ndiff();
    checks++;
    if (d != 0 || out_sel !== 3'd2 || fill_count !== CNT_W'(SIZE)) begin
      errors++;
      $display("FAIL stream_data: diffs=%0d sel=%0d fc=%0d want 0 2 %0d",
               d, out_sel, fill_count, SIZE);
    end
    checks++;
    if (sel_err !== 1'b0 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL stream_flags: sel_err=%b frame_err=%b want 0 0",
               sel_err, frame_err);
    end
    d = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (out_valid !== 1'b1 || ndiff() != 0 || out_sel !== 3'd2 ||
          fill_count !== CNT_W'(SIZE)) d++;
    end
    checks++;
    if (d != 0) begin
      errors++;
      $display("FAIL stream_hold: unstable cycles=%0d want 0", d);
    end
  endtask

  task automatic test_drain_second();
    int cyc, acc, d;
    drain();
    build_exp(0, 0);
    d = ndiff();
    checks++;
    if (out_valid !== 1'b0 || fill_count !== '0 || d != 0 ||
        in_ready !== 1'b1) begin
      errors++;
      $display("FAIL drain_clear: ov=%b fc=%0d diffs=%0d ir=%b want 0 0 0 1",
               out_valid, fill_count, d, in_ready);
    end
    build_exp(1000, SIZE);
    load(1000, 3'd4, 3'd4, SIZE, SIZE - 1, 1'b0, cyc, acc);
    d = ndiff();
    checks++;
    if (out_valid !== 1'b1 || d != 0 || out_sel !== 3'd4 ||
        fill_count !== CNT_W'(SIZE)) begin
      errors++;
      $display("FAIL second_vec: ov=%b diffs=%0d sel=%0d fc=%0d want 1 0 4 %0d",
               out_valid, d, out_sel, fill_count, SIZE);
    end
  endtask

  task automatic test_gaps();
    int cyc, acc, d;
    build_exp(1, SIZE);
    load(1, 3'd2, 3'd2, SIZE, SIZE - 1, 1'b1, cyc, acc);
    d = ndiff();
    checks++;
    if (cyc != 2 * SIZE - 1 || out_valid !== 1'b1 || pre_bad != 0) begin
      errors++;
      $display("FAIL gaps_timing: cyc=%0d ov=%b early=%0d want %0d 1 0",
               cyc, out_valid, pre_bad, 2 * SIZE - 1);
    end
    checks++;
    if (d != 0 || out_sel !== 3'd2) begin
      errors++;
      $display("FAIL gaps_data: diffs=%0d sel=%0d want 0 2", d, out_sel);
    end
  endtask

  task automatic test_sel_reserved();
    int cyc, acc;
    load(5, 3'd3, 3'd3, SIZE, SIZE - 1, 1'b0, cyc, acc);
    checks++;
    if (out_valid !== 1'b1 || out_sel !== 3'd0 || sel_err !== 1'b1) begin
      errors++;
      $display("FAIL sel_reserved: ov=%b sel=%0d err=%b want 1 0 1",
               out_valid, out_sel, sel_err);
    end
    drain();
    load(9, 3'd1, 3'd3, SIZE, SIZE - 1, 1'b0, cyc, acc);
    checks++;
    if (out_valid !== 1'b1 || out_sel !== 3'd1 || sel_err !== 1'b1) begin
      errors++;
      $display("FAIL sel_sticky: ov=%b sel=%0d err=%b want 1 1 1",
               out_valid, out_sel, sel_err);
    end
  endtask

  task automatic test_mid_reset();
    int cyc, acc, d;
    drain();
    load(50, 3'd6, 3'd6, 100, SIZE - 1, 1'b0, cyc, acc);
    checks++;
    if (fill_count !== CNT_W'(100)) begin
      errors++;
      $display("FAIL mid_count: fc=%0d want 100", fill_count);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    build_exp(0, 0);
    d = ndiff();
    checks++;
    if (fill_count !== '0 || out_valid !== 1'b0 || d != 0 ||
        sel_err !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: fc=%0d ov=%b diffs=%0d serr=%b want 0 0 0 0",
               fill_count, out_valid, d, sel_err);
    end
    build_exp(7, SIZE);
    load(7, 3'd5, 3'd5, SIZE, SIZE - 1, 1'b0, cyc, acc);
    d = ndiff();
    checks++;
    if (out_valid !== 1'b1 || d != 0 || out_sel !== 3'd5 ||
        fill_count !== CNT_W'(SIZE)) begin
      errors++;
      $display("FAIL post_reset_vec: ov=%b diffs=%0d sel=%0d fc=%0d want 1 0 5 %0d",
               out_valid, d, out_sel, fill_count, SIZE);
    end
  endtask

  task automatic test_last();
    int cyc, acc, d;
    drain();
    load(1, 3'd2, 3'd2, SIZE, 84, 1'b0, cyc, acc);
`ifdef PERM_VECTOR_LOADER_LAST_CHECK_EN
    build_exp(1, 85);
    d = ndiff();
    checks++;
    if (acc != 85 || out_valid !== 1'b1 || fill_count !== CNT_W'(85) ||
        d != 0) begin
      errors++;
      $display("FAIL last_early: acc=%0d ov=%b fc=%0d diffs=%0d want 85 1 85 0",
               acc, out_valid, fill_count, d);
    end
    checks++;
    if (frame_err !== 1'b1) begin
      errors++;
      $display("FAIL last_frame_err: got %b want 1", frame_err);
    end
`else
    build_exp(1, SIZE);
    d = ndiff();
    checks++;
    if (acc != SIZE || out_valid !== 1'b1 || fill_count !== CNT_W'(SIZE) ||
        d != 0) begin
      errors++;
      $display("FAIL last_ignored: acc=%0d ov=%b fc=%0d diffs=%0d want %0d 1 %0d 0",
               acc, out_valid, fill_count, d, SIZE, SIZE);
    end
    checks++;
    if (frame_err !== 1'b0) begin
      errors++;
      $display("FAIL last_frame_err: got %b want 0", frame_err);
    end
`endif
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    pre_bad   = 0;
    rst       = 1'b1;
    in_data   = '0;
    in_valid  = 1'b0;
    in_sel    = 3'd0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    exp_v     = '0;
    test_reset();
    test_stream();
    test_drain_second();
    drain();
    test_gaps();
    drain();
    test_sel_reserved();
    test_mid_reset();
    test_last();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/perm_vector_loader.md
Name: perm_vector_loader

Overview:
- Upstream feeder for the 257-point permutation network in the non-power-of-two NTT datapath.
- Collects a serial stream of WIDTH-bit coefficients, one per accepted beat, into a SIZE-element vector register.
- Presents that vector, together with its 3-bit permutation select, to the permutation stage under a valid/ready handshake.
- Holds the vector stable until the consumer accepts it, then clears and refills.

Parameters:
- SIZE, 257, number of elements per vector (element 0 is the first word received).
- WIDTH, 32, bits per element.
- CNT_W, $clog2(SIZE+1), width of the fill counter; derived, not overridden.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  WIDTH  coefficient word.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader accepts in_data this cycle.
- in_sel  input  3  permutation select; sampled only on the beat that writes element 0.
- in_last  input  1  end-of-vector marker; used only with the optional feature.
- out_list  output  SIZE x WIDTH  packed vector; element i at out_list[i].
- out_sel  output  3  select captured for this vector.
- out_valid  output  1  out_list/out_sel are complete and stable.
- out_ready  input  1  downstream consumes the vector.
- fill_count  output  CNT_W  number of elements written into the current vector.
- sel_err  output  1  sticky flag: a reserved select value was received.
- frame_err  output  1  sticky flag: in_last mismatch (optional feature only).

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - state=FILL, fill_count=0, out_valid=0, out_sel=0, out_list all zeros.
  - sel_err=0, frame_err=0, in_ready=0 during the reset cycle.
  - Reset mid-fill or mid-hold discards the partial or complete vector. No output handshake occurs.
- Accept: acc = in_valid & in_ready.
- Output handshake: fire = out_valid & out_ready.
- in_ready is registered-state only (in_ready = state==FILL & ~rst). There is no combinational path from out_ready to in_ready.
- State FILL:
  - in_ready=1, out_valid=0.
  - On acc: element[fill_count] <= in_data and fill_count <= fill_count+1.
  - On acc with fill_count==0: out_sel <= in_sel. If in_sel==3, store 0 and set sel_err (3 is reserved).
  - On acc with fill_count==SIZE-1: state <= FULL, out_valid <= 1 on the next cycle.
  - No acc: everything holds. Gaps in in_valid are legal at any index.
- State FULL:
  - in_ready=0, out_valid=1.
  - out_list, out_sel and fill_count (=SIZE) are held stable while out_ready=0.
  - On fire: state <= FILL, fill_count <= 0, out_valid <= 0, all elements cleared to 0. The first word of the next vector can be accepted the cycle after fire.
- Throughput: at most one vector per SIZE+1 cycles. Latency from last accepted word to out_valid=1 is 1 cycle.
- out_list is a direct register output with no combinational logic after the flops. The permutation stage consumes it combinationally.
- sel_err and frame_err clear only on rst.
- Writing past SIZE-1 cannot occur because in_ready=0 in FULL.

Optional Feature:
- Macro: PERM_VECTOR_LOADER_LAST_CHECK_EN.
- With the macro defined:
  - in_last is checked on every acc.
  - in_last=1 at fill_count<SIZE-1 closes the vector early: state <= FULL, unwritten elements remain 0, fill_count shows the words actually written, and frame_err is set.
  - in_last=0 on the word at index SIZE-1 also sets frame_err. The vector still closes normally.
- Without the macro: in_last is ignored and frame_err is tied to 0.

Test Plan:
- Reset, then stream data=i+1 for i=0..256 with in_sel=2, in_valid held high and out_ready=0:
  - in_ready high for 257 cycles.
  - out_valid=1 exactly 1 cycle after the last beat.
  - out_list[i]=i+1, out_sel=2, fill_count=257.
  - Vector held stable for 20 cycles.
- Same stream with in_valid toggled 1/0 every cycle -> identical out_list; out_valid after 513 cycles.
- Assert out_ready during FULL:
  - out_valid drops the next cycle, fill_count=0, out_list all 0.
  - A second vector with data=1000+i and in_sel=4 is loaded correctly, with no carry-over from the first.
- in_sel=3 on the first word -> out_sel=0, sel_err=1 and stays 1 through the next vector. in_sel=3 on any later word has no effect.
- Assert rst at fill_count=100 -> fill_count=0, out_list all 0, out_valid=0. A subsequent full vector loads cleanly.
- With PERM_VECTOR_LOADER_LAST_CHECK_EN: in_last=1 on word index 84:
  - out_valid rises, fill_count=85, elements 85..256 = 0, frame_err=1.
- Without the macro, the same stimulus -> frame_err=0 and the loader waits for 257 words.
